// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
// Shared types and helpers for the PS/2 host-to-device transmitter and its
// input line filter.
//   ps2tx_state_t : transmitter FSM states
//   FILTER_LEN    : consecutive equal samples needed before a filtered pin
//                   level is allowed to change
//   odd_parity()  : PS/2 frame parity bit for a data byte
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2tx_state_t;

  localparam int FILTER_LEN = 8;

  // PS/2 uses odd parity: the bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 pin: a 2-FF synchronizer followed by a stability
// filter. The filtered level only moves after FILTER_LEN consecutive
// synchronized samples disagree with it, so short glitches are dropped.
// Ports:
//   clk28  : system clock
//   rst_n  : asynchronous reset, active low (everything presets to 1)
//   pin_in : raw, asynchronous pin level
//   level  : synchronized, filtered pin level
module ps2_line_filter
  import ps2_host_tx_pkg::*;
(
  input  logic clk28,
  input  logic rst_n,
  input  logic pin_in,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt holds how many samples in a row have disagreed with level; the
  // FILTER_LEN-th disagreeing sample commits the new level.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte using the
// open-collector request-to-send sequence and checks the device acknowledge.
// Ports:
//   clk28, rst_n           : system clock, async active-low reset
//   tx_data, tx_valid      : command byte and send request
//   tx_ready               : high when a byte can be accepted
//   tx_done, tx_err        : one-cycle result pulses (acked / nack or timeout)
//   rx_inhibit             : tells the shared receiver to ignore the pins
//   ps2_clk_in, ps2_dat_in : raw PS/2 pin levels
//   ps2_clk_oe, ps2_dat_oe : 1 = pull the pin low, 0 = release
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ = 28_000_000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int T100 = CLK_FREQ / 10000;
  localparam int T5   = CLK_FREQ / 200000;
  localparam int TTO  = CLK_FREQ * 15 / 1000;
  localparam int TW   = $clog2(TTO + 1);

  logic clk_filt;
  logic dat_filt;
  logic clk_prev;
  logic clk_fall;

  ps2tx_state_t  state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [3:0]    bit_n, bit_n_nx;
  logic [9:0]    frame, frame_nx;
  logic          ready_nx, inhibit_nx, done_nx, err_nx;
  logic          clk_oe_nx, dat_oe_nx;

  ps2_line_filter u_clk_filter (
    .clk28  (clk28),
    .rst_n  (rst_n),
    .pin_in (ps2_clk_in),
    .level  (clk_filt)
  );

  ps2_line_filter u_dat_filter (
    .clk28  (clk28),
    .rst_n  (rst_n),
    .pin_in (ps2_dat_in),
    .level  (dat_filt)
  );

  assign clk_fall = clk_prev & ~clk_filt;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      bit_n      <= '0;
      frame      <= '0;
      clk_prev   <= 1'b1;
      tx_ready   <= 1'b1;
      rx_inhibit <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_nx;
      tmr        <= tmr_nx;
      bit_n      <= bit_n_nx;
      frame      <= frame_nx;
      clk_prev   <= clk_filt;
      tx_ready   <= ready_nx;
      rx_inhibit <= inhibit_nx;
      tx_done    <= done_nx;
      tx_err     <= err_nx;
      ps2_clk_oe <= clk_oe_nx;
      ps2_dat_oe <= dat_oe_nx;
    end
  end

  // tmr times the INHIBIT and RTS phases, then is reused as the overall
  // timeout counter from clock release until the return to IDLE.
  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    bit_n_nx  = bit_n;
    frame_nx  = frame;
    clk_oe_nx = ps2_clk_oe;
    dat_oe_nx = ps2_dat_oe;
    done_nx   = 1'b0;
    err_nx    = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_nx  = {1'b1, odd_parity(tx_data), tx_data};
          tmr_nx    = '0;
          bit_n_nx  = '0;
          clk_oe_nx = 1'b1;
          state_nx  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tmr == TW'(T100 - 1)) begin
          tmr_nx    = '0;
          dat_oe_nx = 1'b1;
          state_nx  = RTS;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      RTS: begin
        if (tmr == TW'(T5 - 1)) begin
          tmr_nx    = '0;
          clk_oe_nx = 1'b0;
          state_nx  = SHIFT;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      default: begin
        tmr_nx = tmr + TW'(1);
        // The timeout is checked first so it wins over a same-cycle ack.
        if (tmr == TW'(TTO - 1)) begin
          clk_oe_nx = 1'b0;
          dat_oe_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end else begin
          case (state)
            SHIFT: begin
              if (clk_fall) begin
                dat_oe_nx = ~frame[bit_n];
                if (bit_n == 4'd9) begin
                  state_nx = ACK;
                end else begin
                  bit_n_nx = bit_n + 4'd1;
                end
              end
            end
            ACK: begin
              dat_oe_nx = 1'b0;
              if (clk_fall) begin
                if (dat_filt) begin
                  err_nx   = 1'b1;
                  state_nx = IDLE;
                end else begin
                  state_nx = WAIT_IDLE;
                end
              end
            end
            WAIT_IDLE: begin
              if (clk_filt && dat_filt) begin
                done_nx  = 1'b1;
                state_nx = IDLE;
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
    endcase

    // Ready only after a full cycle spent in IDLE, so it rises the cycle
    // after a done/err pulse and drops on the accept edge.
    ready_nx   = (state == IDLE) && (state_nx == IDLE);
    inhibit_nx = ~ready_nx;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Drives ps2_host_tx with a behavioural PS/2 keyboard model on open-collector
// lines and compares the captured frames and handshake timing against values
// computed from the protocol rules.
module tb_ps2_host_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int T100     = CLK_FREQ / 10000;
  localparam int T5       = CLK_FREQ / 200000;
  localparam int TTO      = CLK_FREQ * 15 / 1000;

  logic       clk28    = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  int   err_cnt     = 0;
  logic prev_pulse  = 1'b0;

  // Open-collector wiring: a line is low if either side pulls it.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk28 = ~clk28;

  initial begin
    #(10 * 100000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Frame as the keyboard should see it: D0..D7, odd parity, stop.
  function automatic logic [9:0] refFrame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0), d};
  endfunction

  // Result pulses: counted, and the surrounding handshake checked.
  always @(negedge clk28) begin
    if (!rst_n) begin
      prev_pulse <= 1'b0;
    end else begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err)  err_cnt  <= err_cnt + 1;
      if (tx_done || tx_err)
        checkOutput("pulse_cycle", {tx_ready, tx_done & tx_err, ps2_clk_oe, ps2_dat_oe}, 4'b0000);
      if (prev_pulse)
        checkOutput("after_pulse", {tx_ready, rx_inhibit, tx_done | tx_err}, 3'b100);
      prev_pulse <= tx_done | tx_err;
    end
  end

  // mode: 0 = ack, 1 = no ack, 2 = silent device, 3 = clock glitch plus
  // tx_valid while busy, 4 = reset mid-frame.
  task automatic applyStimulus(input logic [7:0] data, input int mode);
    int         cnt, half, lat, d0, e0, exp_done, exp_err;
    logic [9:0] cap, exp_frame;
    logic       aborted;
    half      = $urandom_range(30, 50);
    cap       = '0;
    lat       = 0;
    aborted   = 1'b0;
    exp_frame = refFrame(data);

    cnt = 0;
    while (!tx_ready && cnt < 5000) begin
      @(negedge clk28);
      cnt++;
    end
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk28);
    tx_valid = 1'b0;
    checkOutput("accept", {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready}, 4'b1010);

    cnt = 0;
    while (ps2_clk_oe && !ps2_dat_oe && cnt < T100 + 10) begin
      cnt++;
      @(negedge clk28);
    end
    checkOutput("inhibit_len", cnt, T100);
    cnt = 0;
    while (ps2_clk_oe && ps2_dat_oe && cnt < T5 + 10) begin
      cnt++;
      @(negedge clk28);
    end
    checkOutput("rts_len", cnt, T5);
    checkOutput("release", {ps2_clk_oe, ps2_dat_oe}, 2'b01);

    if (mode == 2) begin
      cnt = 0;
      while (!tx_err && cnt < TTO + 50) begin
        @(negedge clk28);
        cnt++;
      end
      checkOutput("timeout_len", cnt, TTO);
      checkOutput("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    end else begin
      for (int i = 0; i < 11 && !aborted; i++) begin
        if (i == 10 && mode != 1) dev_dat = 1'b0;
        for (int c = 0; c < half && !aborted; c++) begin
          @(negedge clk28);
          dev_clk = !(mode == 3 && i == 3 && c >= 10 && c < 13);
          if (mode == 3 && i == 5) begin
            tx_valid = (c == 5);
            tx_data  = ~data;
            if (c == 5) checkOutput("busy_ready", tx_ready, 1'b0);
          end
          if (mode == 4 && i == 4 && c == 5) begin
            #3 rst_n = 1'b0;
            #1 checkOutput("reset_abort",
                           {ps2_clk_oe, ps2_dat_oe, tx_ready, rx_inhibit, tx_done, tx_err},
                           6'b001000);
            aborted = 1'b1;
          end
        end
        if (i == 0 && !aborted) checkOutput("start_bit", ps2_dat_in, 1'b0);
        if (!aborted) begin
          dev_clk = 1'b0;
          for (int c = 1; c <= half; c++) begin
            @(negedge clk28);
            if (i == 0 && lat == 0 && !ps2_dat_oe) lat = c;
          end
          if (i < 10) cap[i] = ps2_dat_in;
          dev_clk = 1'b1;
        end
      end
      dev_dat = 1'b1;
      if (aborted) begin
        dev_clk = 1'b1;
        @(negedge clk28);
        rst_n = 1'b1;
        repeat (40) @(negedge clk28);
      end else begin
        checkOutput("frame", cap, exp_frame);
        checkOutput("parity", cap[8], exp_frame[8]);
        if (data[0]) checkOutput("fall_latency", lat, 11);
      end
    end

    cnt = 0;
    while (!tx_ready && cnt < 200) begin
      @(negedge clk28);
      cnt++;
    end
    exp_done = (mode == 0 || mode == 3) ? 1 : 0;
    exp_err  = (mode == 1 || mode == 2) ? 1 : 0;
    checkOutput("done_count", done_cnt - d0, exp_done);
    checkOutput("err_count", err_cnt - e0, exp_err);
    checkOutput("idle_state", {tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    if (mode == 3) begin
      tx_data = 8'h00;
      repeat (5) @(negedge clk28);
      checkOutput("not_queued", {ps2_clk_oe, rx_inhibit}, 2'b00);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk28);
    checkOutput("reset_outputs",
                {tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
    rst_n = 1'b1;
    @(negedge clk28);

    applyStimulus(8'hED, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h01, 0);
    for (int k = 0; k < 5; k++) applyStimulus(8'($urandom), int'($urandom_range(0, 1)));
    applyStimulus(8'h5A, 3);
    applyStimulus(8'hA7, 0);
    applyStimulus(8'h3C, 1);
    applyStimulus(8'hF3, 2);
    applyStimulus(8'h96, 4);
    applyStimulus(8'hFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example LED set (0xED), reset (0xFF) or typematic rate (0xF3). It uses the open-collector request-to-send sequence and checks the device acknowledge. It shares the PS/2 pins with the existing PS/2 receiver in the top level, and asserts an inhibit output so the receiver ignores the host frame.

## Interface
- CLK_FREQ, 28_000_000, clock frequency in Hz; all timing constants derive from it.
- clk28  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- tx_data  input  8  command byte; sampled on accept.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
- tx_done  output  1  one-cycle pulse: byte sent and device acknowledged.
- tx_err  output  1  one-cycle pulse: no acknowledge, or timeout.
- rx_inhibit  output  1  high from accept until return to IDLE; the receiver must discard bits while high.
- ps2_clk_in  input  1  raw PS/2 clock pin.
- ps2_dat_in  input  1  raw PS/2 data pin.
- ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release.
- ps2_dat_oe  output  1  1 = drive PS/2 data low; 0 = release.

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer, then a stability filter.
  - The filtered level changes only after 8 consecutive equal samples.
  - A clock falling edge is detected on the filtered clock.
- States and transitions:
  - IDLE: both oe = 0. On accept, latch the byte, compute odd parity (~^tx_data), clear the timers, go to INHIBIT.
  - INHIBIT: clk_oe = 1, dat_oe = 0 for T100 = CLK_FREQ/10000 cycles (2800), then RTS.
  - RTS: clk_oe = 1, dat_oe = 1 (start bit) for T5 = CLK_FREQ/200000 cycles (140), then SHIFT with clk_oe = 0.
  - SHIFT: 4-bit counter n = 0..9. On each filtered clock falling edge, present frame bit n: D0..D7 LSB first, then parity, then stop = 1. dat_oe = ~bit. After the stop bit is presented, go to ACK.
  - ACK: dat_oe = 0. On the next falling edge, sample filtered data. Low: go to WAIT_IDLE. High: pulse tx_err, go to IDLE.
  - WAIT_IDLE: when filtered clock and data are both high, pulse tx_done and go to IDLE.
- Timeout:
  - A counter runs from leaving RTS until IDLE.
  - At TTO = CLK_FREQ*15/1000 cycles (420000), release both lines, pulse tx_err, go to IDLE.
  - Counter width is $clog2(TTO+1).
- tx_valid while not ready is ignored; the byte is not queued.

## Timing
- Reset values:
  - State IDLE, tx_ready = 1.
  - tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe = 0.
  - Filters preset to 1.
- Reset mid-operation releases both lines asynchronously and abandons the byte; no done or error pulse is produced.
- Accept cycle → clk_oe high on the next cycle; rx_inhibit rises on the same edge.
- Pin falling edge → ps2_dat_oe updated 11 clk28 cycles later (2 sync + 8 filter + 1 register). That is 0.4 µs, well inside the device's half-period of at least 30 µs.
- tx_done and tx_err are mutually exclusive. Each coincides with the transition to IDLE. tx_ready returns high on the cycle after the pulse; rx_inhibit falls with tx_ready rising.
- Back-to-back sends: a new accept is possible on the first cycle tx_ready is high.
- If a timeout and an ack sample fall in the same cycle, the timeout wins and tx_err pulses once.
- All outputs are registered; oe outputs are glitch-free.

## Structure
- Package common: typedef enum ps2tx_state_t {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE}. The tick constants are localparams inside the module, derived from CLK_FREQ.
- Sub-module ps2_line_filter: synchronizer plus 8-sample stability filter, one instance per pin. The PS/2 receiver can reuse it later.
- Top-level wiring:
  - ps2_clk = ps2_clk_oe ? 1'b0 : 1'bz, and the same form for data.
  - rx_inhibit gates the receiver's shift input.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz:
  - Clock is held low 2800 cycles, then data low for 140 cycles before clock release.
  - Model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Model acks; one tx_done pulse, no tx_err.
- Parity: 0x00 → parity 1; 0xFF → parity 1; 0x01 → parity 0. Stop bit is always 1.
- Model leaves data high on the 11th clock → exactly one tx_err, no tx_done, lines released, tx_ready back to 1.
- Device silent after RTS → tx_err exactly 420000 cycles after clock release; both oe = 0.
- tx_valid pulsed during SHIFT → ignored, frame unchanged. A second byte issued the first ready cycle after done is transmitted correctly.
- Edge cases:
  - A 3-cycle low glitch on ps2_clk_in during SHIFT → no bit advance.
  - rst_n asserted mid-SHIFT → both oe = 0 immediately, state IDLE, no pulses.
